// File: rtl/lcd_host_driver_if.sv
// Host <-> LCD controller link: command handshake, IROM read bus, IRAM write stream.
// Latency: none; this is a bundle of wires.
// Backpressure: the controller's busy line gates command issue; the read and write buses have no stall.
interface lcd_host_driver_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;

    // Host side: issues commands, serves image reads, sinks result writes
    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
    );

    // Controller side
    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
    );
endinterface

// File: rtl/lcd_host_driver.sv
// Host driver for the LCD controller: serves the image, issues queued commands, captures results.
// Latency: IROM_Q and res_data are combinational; a command strobes 1 cycle after busy is seen low.
// Backpressure: commands wait on busy low and then on busy high before the next one; pushes to a full queue are dropped.
module lcd_host_driver #(
    parameter int CQ_DEPTH = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  img_we,
    input  logic [5:0]            img_addr,
    input  logic [7:0]            img_data,
    input  logic                  cq_push,
    input  logic [3:0]            cq_data,
    output logic                  cq_full,
    input  logic                  start,
    lcd_host_driver_if.master     ctl,
    input  logic [5:0]            res_addr,
    output logic [7:0]            res_data,
    output logic [13:0]           checksum,
    output logic                  finished,
    output logic                  timeout_err
);

    localparam int PW = $clog2(CQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t         state;
    logic [TW-1:0]  tmr;
    logic           tmo;
    logic [3:0]     cmd_r;
    logic           cmd_valid_r;

    // ---------------- image memory ----------------
    logic [7:0] img [64];

    // Image preload; deliberately not reset so a reset keeps the loaded picture
    always_ff @(posedge clk) begin
        if (img_we) begin
            img[img_addr] <= img_data;
        end
    end

    // Zero-latency read: the controller samples in the same cycle it drives the address
    assign ctl.IROM_Q = ctl.IROM_rd ? img[ctl.IROM_A] : 8'd0;

    // ---------------- command queue ----------------
    logic [3:0]    cq_mem [CQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cq_count;
    logic          cq_empty;
    logic          do_push;
    logic          do_pop;
    logic          do_flush;
    logic [3:0]    cq_head;

    assign cq_empty = (cq_count == '0);
    assign cq_full  = (cq_count == CW'(CQ_DEPTH));
    assign do_push  = cq_push && !cq_full;
    assign do_pop   = (state == ISSUE) && !cq_empty;
    // Issuing write-out ends the sequence, so anything still queued behind it is discarded
    assign do_flush = (state == ISSUE) && (cmd_r == 4'd0);
    assign cq_head  = cq_mem[rd_ptr];

    // Queue pointers and occupancy; a flush wins over a simultaneous push
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cq_count <= '0;
        end else if (do_flush) begin
            rd_ptr   <= wr_ptr;
            cq_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cq_count <= cq_count + CW'(1);
                2'b01:   cq_count <= cq_count - CW'(1);
                default: cq_count <= cq_count;
            endcase
        end
    end

    // Queue storage write
    always_ff @(posedge clk) begin
        if (do_push && !do_flush) begin
            cq_mem[wr_ptr] <= cq_data;
        end
    end

    // ---------------- sequencer ----------------
    // Counter reaches TIMEOUT on the edge where it reads TIMEOUT-1
    assign tmo = (tmr == TW'(TIMEOUT - 1));

    // Command sequencer; the wait counter is cleared on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            cmd_r       <= 4'd0;
            cmd_valid_r <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tmr         <= tmr + TW'(1);
            cmd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tmr <= '0;
                        if (cq_empty) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (!ctl.busy) begin
                        tmr <= '0;
                        // Queue drained without a write-out command: nothing left to do
                        if (cq_empty) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            cmd_r       <= cq_head;
                            cmd_valid_r <= 1'b1;
                        end
                    end else if (tmo) begin
                        tmr         <= '0;
                        state       <= FINISH;
                        finished    <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                ISSUE: begin
                    tmr   <= '0;
                    state <= (cmd_r == 4'd0) ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Wait for the controller to take the command before looking for ready again
                    if (ctl.busy) begin
                        tmr   <= '0;
                        state <= WAIT_RDY;
                    end else if (tmo) begin
                        tmr         <= '0;
                        state       <= FINISH;
                        finished    <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ctl.done) begin
                        tmr      <= '0;
                        state    <= FINISH;
                        finished <= 1'b1;
                    end else if (tmo) begin
                        tmr         <= '0;
                        state       <= FINISH;
                        finished    <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                FINISH: begin
                    if (start) begin
                        tmr      <= '0;
                        state    <= IDLE;
                        finished <= 1'b0;
                    end
                end
                default: begin
                    tmr   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ctl.cmd       = cmd_r;
    assign ctl.cmd_valid = cmd_valid_r;

    // ---------------- result capture ----------------
    logic [7:0] res [64];
    logic [7:0] res_old;
    logic       clear_res;

    assign res_old   = res[ctl.IRAM_A];
    assign clear_res = (state == FINISH) && start;
    assign res_data  = res[res_addr];

    // Result buffer and running sum; replacing the old byte keeps the sum exact on rewrites
    always_ff @(posedge clk) begin
        if (reset || clear_res) begin
            for (int i = 0; i < 64; i++) begin
                res[i] <= 8'd0;
            end
            checksum <= 14'd0;
        end else if (ctl.IRAM_valid) begin
            res[ctl.IRAM_A] <= ctl.IRAM_D;
            checksum        <= checksum - {6'd0, res_old} + {6'd0, ctl.IRAM_D};
        end
    end

endmodule

// File: tb/tb_lcd_host_driver.sv
// Bench for lcd_host_driver with a behavioural controller stub and scoreboard monitors.
// Latency: n/a.
// Backpressure: stub drives busy exactly as the real controller handshake does.
module tb_lcd_host_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_we;
    logic [5:0]  img_addr;
    logic [7:0]  img_data;
    logic        cq_push;
    logic [3:0]  cq_data;
    logic        cq_full;
    logic        start;
    logic [5:0]  res_addr;
    logic [7:0]  res_data;
    logic [13:0] checksum;
    logic        finished;
    logic        timeout_err;

    lcd_host_driver_if bus ();

    lcd_host_driver #(.CQ_DEPTH(16), .TIMEOUT(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_data    (img_data),
        .cq_push     (cq_push),
        .cq_data     (cq_data),
        .cq_full     (cq_full),
        .start       (start),
        .ctl         (bus),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .checksum    (checksum),
        .finished    (finished),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] cks;
        logic        terr;
    } fin_t;

    logic [3:0] exp_cmd_q [$];
    fin_t       exp_fin_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [3:0] d);
        cq_push = 1'b1;
        cq_data = d;
        tick();
        cq_push = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_img(input bit flat);
        for (int i = 0; i < 64; i++) begin
            img_we   = 1'b1;
            img_addr = i[5:0];
            img_data = flat ? 8'h10 : i[7:0];
            tick();
        end
        img_we = 1'b0;
    endtask

    task automatic rd_res(input int a, output logic [7:0] d);
        res_addr = a[5:0];
        #1;
        d = res_data;
    endtask

    task automatic wait_fin(input string nm);
        int t = 0;
        while (!finished && t < 5000) begin
            tick();
            t++;
        end
        chk(nm, finished, 1);
    endtask

    // Controller stub: 64-cycle image load, then serves ncmds commands; cmd 0 streams the
    // image back unchanged plus a trailing repeat beat with done. abort_beats>=0 stops early.
    task automatic ctl_run(input int ncmds, input int abort_beats);
        logic [7:0] cimg [64];
        logic [3:0] c;
        int         t;
        bit         aborted;
        aborted  = 1'b0;
        bus.busy = 1'b1;
        for (int a = 0; a < 64; a++) begin
            bus.IROM_rd = 1'b1;
            bus.IROM_A  = a[5:0];
            #1;
            cimg[a] = bus.IROM_Q;
            tick();
        end
        bus.IROM_rd = 1'b0;
        bus.IROM_A  = 6'd0;
        bus.busy    = 1'b0;
        for (int n = 0; n < ncmds; n++) begin
            t = 0;
            while (!bus.cmd_valid && t < 2000) begin
                tick();
                t++;
            end
            if (!bus.cmd_valid) begin
                checks++;
                errors++;
                $display("FAIL ctl_cmd_wait got no cmd_valid want cmd %0d of %0d", n, ncmds);
                return;
            end
            c = bus.cmd;
            tick();
            bus.busy = 1'b1;
            repeat (3) tick();
            if (c == 4'd0) begin
                for (int a = 0; a < 64 && !aborted; a++) begin
                    if (abort_beats >= 0 && a == abort_beats) begin
                        aborted = 1'b1;
                    end else begin
                        bus.IRAM_valid = 1'b1;
                        bus.IRAM_A     = a[5:0];
                        bus.IRAM_D     = cimg[a];
                        tick();
                    end
                end
                if (aborted) begin
                    bus.IRAM_valid = 1'b0;
                    bus.busy       = 1'b0;
                    return;
                end
                bus.IRAM_A = 6'd63;
                bus.IRAM_D = cimg[63];
                bus.done   = 1'b1;
                tick();
                bus.IRAM_valid = 1'b0;
                bus.done       = 1'b0;
            end
            bus.busy = 1'b0;
        end
    endtask

    // Monitor: every cmd_valid pulse is popped against the expected command stream, must be
    // one cycle wide, and must follow a busy high-then-low sequence since the last pulse/start
    bit saw_hi, armed, prev_cv, prev_fin;
    always @(negedge clk) begin
        if (reset) begin
            saw_hi   = 1'b0;
            armed    = 1'b0;
            prev_cv  = 1'b0;
            prev_fin = 1'b0;
        end else begin
            if (start) begin
                saw_hi = 1'b0;
                armed  = 1'b0;
            end
            if (bus.cmd_valid) begin
                chk("cmd_valid_single", prev_cv, 0);
                if (!prev_cv) begin
                    if (exp_cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd got %0d want no pulse", bus.cmd);
                    end else begin
                        chk("cmd", bus.cmd, exp_cmd_q.pop_front());
                        chk("busy_handshake", armed, 1);
                    end
                    saw_hi = 1'b0;
                    armed  = 1'b0;
                end
            end
            if (bus.busy) saw_hi = 1'b1;
            else if (saw_hi) armed = 1'b1;
            if (finished && !prev_fin) begin
                if (exp_fin_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish got checksum %0d want no finish", checksum);
                end else begin
                    fin_t f;
                    f = exp_fin_q.pop_front();
                    chk("fin_checksum", checksum, f.cks);
                    chk("fin_timeout_err", timeout_err, f.terr);
                end
            end
            prev_cv  = bus.cmd_valid;
            prev_fin = finished;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no end want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;
        reset = 1'b1; img_we = 1'b0; img_addr = 6'd0; img_data = 8'd0;
        cq_push = 1'b0; cq_data = 4'd0; start = 1'b0; res_addr = 6'd0;
        bus.busy = 1'b0; bus.done = 1'b0; bus.IROM_rd = 1'b0; bus.IROM_A = 6'd0;
        bus.IRAM_valid = 1'b0; bus.IRAM_A = 6'd0; bus.IRAM_D = 8'd0;
        repeat (3) tick();
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cq_full", cq_full, 0);
        chk("rst_finished", finished, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_checksum", checksum, 0);
        rd_res(0, d);
        chk("rst_res0", d, 0);
        reset = 1'b0;
        tick();

        // T1: ramp image, single write-out command
        load_img(1'b0);
        push(4'd0);
        exp_cmd_q.push_back(4'd0);
        exp_fin_q.push_back({14'd2016, 1'b0});
        fork
            ctl_run(1, -1);
            pulse_start();
        join
        wait_fin("t1_finished");
        for (int i = 0; i < 64; i++) begin
            rd_res(i, d);
            chk($sformatf("t1_res%0d", i), d, i);
        end
        chk("t1_checksum", checksum, 2016);
        repeat (2) tick();

        // T2: start from FINISH clears buffer; flat image, commands {5,0}
        pulse_start();
        tick();
        chk("t2_cleared_finished", finished, 0);
        chk("t2_cleared_checksum", checksum, 0);
        rd_res(7, d);
        chk("t2_cleared_res7", d, 0);
        load_img(1'b1);
        push(4'd5);
        push(4'd0);
        exp_cmd_q.push_back(4'd5);
        exp_cmd_q.push_back(4'd0);
        exp_fin_q.push_back({14'd1024, 1'b0});
        fork
            ctl_run(2, -1);
            pulse_start();
        join
        wait_fin("t2_finished");
        rd_res(9, d);
        chk("t2_res9", d, 8'h10);
        repeat (2) tick();
        chk("t2_cmds_left", exp_cmd_q.size(), 0);

        // T3: 17 pushes into a 16-deep queue; the trailing 0 must be dropped
        do_reset();
        for (int i = 1; i <= 15; i++) push(i[3:0]);
        chk("t3_not_full_15", cq_full, 0);
        push(4'd9);
        chk("t3_full_16", cq_full, 1);
        push(4'd0);
        chk("t3_full_17", cq_full, 1);
        for (int i = 1; i <= 15; i++) exp_cmd_q.push_back(i[3:0]);
        exp_cmd_q.push_back(4'd9);
        exp_fin_q.push_back({14'd0, 1'b0});
        fork
            ctl_run(16, -1);
            pulse_start();
        join
        wait_fin("t3_finished");
        repeat (5) tick();
        chk("t3_cmds_left", exp_cmd_q.size(), 0);
        chk("t3_full_after", cq_full, 0);

        // T4: controller stuck busy -> timeout after exactly TIMEOUT cycles in WAIT_RDY
        do_reset();
        push(4'd3);
        bus.busy = 1'b1;
        exp_fin_q.push_back({14'd0, 1'b1});
        pulse_start();
        n = 0;
        while (!timeout_err && n < 2000) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 1024);
        chk("t4_finished", finished, 1);
        tick();
        bus.busy = 1'b0;
        tick();

        // T5: direct rewrites of one address; IROM read gating
        do_reset();
        bus.IRAM_valid = 1'b1;
        bus.IRAM_A = 6'd5;
        bus.IRAM_D = 8'd200;
        tick();
        chk("t5_checksum_200", checksum, 200);
        bus.IRAM_D = 8'd50;
        tick();
        bus.IRAM_valid = 1'b0;
        rd_res(5, d);
        chk("t5_res5", d, 50);
        chk("t5_checksum_50", checksum, 50);
        bus.IROM_A = 6'd5;
        #1;
        chk("t5_irom_gated", bus.IROM_Q, 0);
        bus.IROM_rd = 1'b1;
        #1;
        chk("t5_irom_read", bus.IROM_Q, 8'h10);
        bus.IROM_rd = 1'b0;
        tick();

        // T6: reset during WAIT_DONE, then a clean rerun on the preserved image
        push(4'd0);
        exp_cmd_q.push_back(4'd0);
        fork
            ctl_run(1, 20);
            pulse_start();
        join
        chk("t6_partial_checksum", checksum, 320);
        reset = 1'b1;
        tick();
        chk("t6_rst_cmd_valid", bus.cmd_valid, 0);
        chk("t6_rst_finished", finished, 0);
        chk("t6_rst_checksum", checksum, 0);
        rd_res(5, d);
        chk("t6_rst_res5", d, 0);
        tick();
        reset = 1'b0;
        tick();
        push(4'd0);
        exp_cmd_q.push_back(4'd0);
        exp_fin_q.push_back({14'd1024, 1'b0});
        fork
            ctl_run(1, -1);
            pulse_start();
        join
        wait_fin("t6_finished");
        rd_res(63, d);
        chk("t6_res63", d, 8'h10);
        repeat (3) tick();

        chk("end_cmd_q_empty", exp_cmd_q.size(), 0);
        chk("end_fin_q_empty", exp_fin_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
